alu_cmd_sequencer: RTL and testbench

//  Upstream issue stage for the combinational 12-bit-in/10-bit-out ALU: buffers operation commands,

---
 rtl/alu_cmd_sequencer_pkg.sv | 43 ++++
 rtl/alu_cmd_sequencer_fifo.sv | 53 +++++
 rtl/alu_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Optional build macro: ALU_ACCUM_EN (adds the accumulate bit to each command).
package alu_pkg;

  localparam int unsigned ARG_W  = 12;
  localparam int unsigned RES_W  = 10;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV = 3'b011;
  localparam logic [OP_W-1:0] OP_AND = 3'b100;
  localparam logic [OP_W-1:0] OP_OR  = 3'b101;
  localparam logic [OP_W-1:0] OP_NOR = 3'b110;
  localparam logic [OP_W-1:0] OP_XOR = 3'b111;

  localparam int unsigned FLAG_NEG  = 0;
  localparam int unsigned FLAG_POS  = 1;
  localparam int unsigned FLAG_ZERO = 2;
  localparam int unsigned FLAG_ERR  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_HOLD
  } seq_state_e;

  typedef struct packed {
`ifdef ALU_ACCUM_EN
    logic             acc;
`endif
    logic [OP_W-1:0]  op;
    logic [ARG_W-1:0] a;
    logic [ARG_W-1:0] b;
  } cmd_t;

  function automatic logic [ARG_W-1:0] sext_res(input logic [RES_W-1:0] r);
    return {{(ARG_W-RES_W){r[RES_W-1]}}, r};
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous command FIFO with first-word fall-through read port.
module alu_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = i_push && !o_full;
    do_pop   = i_pop && !o_empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the combinational ALU: queue, issue, capture, hand off.
// Optional build macro: ALU_ACCUM_EN (i_cmd_acc selects last result as operand A).
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [OP_W-1:0]   i_cmd_op,
  input  logic [ARG_W-1:0]  i_cmd_a,
  input  logic [ARG_W-1:0]  i_cmd_b,
`ifdef ALU_ACCUM_EN
  input  logic              i_cmd_acc,
`endif
  output logic [ARG_W-1:0]  o_alu_arg0,
  output logic [ARG_W-1:0]  o_alu_arg1,
  output logic [OP_W-1:0]   o_alu_oper,
  input  logic [RES_W-1:0]  i_alu_result,
  input  logic [FLAG_W-1:0] i_alu_flag,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [RES_W-1:0]  o_res_data,
  output logic [FLAG_W-1:0] o_res_flag,
  output logic [FLAG_W-1:0] o_sticky_flag,
  input  logic              i_sticky_clr,
  output logic [CNT_W-1:0]  o_done_cnt
);

  seq_state_e        state_q, state_d;
  cmd_t              push_cmd;
  cmd_t              head_cmd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              issue;
  logic              capture;
  logic              handoff;

  logic [ARG_W-1:0]  arg0_q, arg0_d;
  logic [ARG_W-1:0]  arg1_q, arg1_d;
  logic [OP_W-1:0]   oper_q, oper_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic [FLAG_W-1:0] res_flag_q, res_flag_d;
  logic [FLAG_W-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;

  always_comb begin
    push_cmd    = '0;
    push_cmd.op = i_cmd_op;
    push_cmd.a  = i_cmd_a;
    push_cmd.b  = i_cmd_b;
`ifdef ALU_ACCUM_EN
    push_cmd.acc = i_cmd_acc;
`endif
  end

  alu_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_cmd_valid),
    .i_wdata (push_cmd),
    .i_pop   (issue),
    .o_rdata (head_cmd),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: if (i_res_ready) state_d = fifo_empty ? ST_IDLE : ST_EXEC;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand registers only change on issue, so the ALU inputs stay quiet in IDLE/HOLD.
  always_comb begin
    issue   = 1'b0;
    capture = 1'b0;
    handoff = 1'b0;
    case (state_q)
      ST_IDLE: issue = !fifo_empty;
      ST_EXEC: capture = 1'b1;
      ST_HOLD: begin
        handoff = i_res_ready;
        issue   = i_res_ready && !fifo_empty;
      end
      default: ;
    endcase

    arg0_d = arg0_q;
    arg1_d = arg1_q;
    oper_d = oper_q;
    if (issue) begin
      arg0_d = head_cmd.a;
`ifdef ALU_ACCUM_EN
      if (head_cmd.acc) arg0_d = sext_res(res_data_q);
`endif
      arg1_d = head_cmd.b;
      oper_d = head_cmd.op;
    end

    res_data_d = res_data_q;
    res_flag_d = res_flag_q;
    if (capture) begin
      res_data_d = i_alu_result;
      res_flag_d = i_alu_flag;
    end

    sticky_d = i_sticky_clr ? '0 : sticky_q;
    if (capture) sticky_d = sticky_d | i_alu_flag;

    done_cnt_d = handoff ? done_cnt_q + CNT_W'(1) : done_cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      arg0_q     <= '0;
      arg1_q     <= '0;
      oper_q     <= '0;
      res_data_q <= '0;
      res_flag_q <= '0;
      sticky_q   <= '0;
      done_cnt_q <= '0;
    end else begin
      arg0_q     <= arg0_d;
      arg1_q     <= arg1_d;
      oper_q     <= oper_d;
      res_data_q <= res_data_d;
      res_flag_q <= res_flag_d;
      sticky_q   <= sticky_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign o_cmd_ready   = !fifo_full;
  assign o_res_valid   = (state_q == ST_HOLD);
  assign o_alu_arg0    = arg0_q;
  assign o_alu_arg1    = arg1_q;
  assign o_alu_oper    = oper_q;
  assign o_res_data    = res_data_q;
  assign o_res_flag    = res_flag_q;
  assign o_sticky_flag = sticky_q;
  assign o_done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;
`ifdef ALU_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [11:0] cmd_a = '0;
  logic [11:0] cmd_b = '0;
  logic        cmd_acc = 1'b0;
  logic        res_ready = 1'b0;
  logic        sticky_clr = 1'b0;

  logic        cmd_ready;
  logic [11:0] alu_arg0, alu_arg1;
  logic [2:0]  alu_oper;
  logic [9:0]  alu_res;
  logic [3:0]  alu_flag;
  logic        res_valid;
  logic [9:0]  res_data;
  logic [3:0]  res_flag;
  logic [3:0]  sticky;
  logic [15:0] done_cnt;

  typedef struct packed {
    logic [3:0] flag;
    logic [9:0] res;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [11:0] model_last = '0;
  logic [3:0]  model_sticky = '0;
  int unsigned model_done = 0;
  bit          rnd_done = 1'b0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external combinational ALU.
  function automatic logic [13:0] alu_fn(input logic [2:0] op, input logic [11:0] a,
                                         input logic [11:0] b);
    int         sa, sb, full;
    logic       err;
    logic [9:0] r;
    logic [3:0] f;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    err = 1'b0;
    full = 0;
    case (op)
      OP_ADD: full = sa + sb;
      OP_SUB: full = sa - sb;
      OP_MUL: full = sa * sb;
      OP_DIV: if (sb == 0) begin full = 0; err = 1'b1; end else full = sa / sb;
      OP_AND: full = sa & sb;
      OP_OR:  full = sa | sb;
      OP_NOR: full = ~(sa | sb);
      OP_XOR: full = sa ^ sb;
      default: full = 0;
    endcase
    if (full > 511 || full < -512) err = 1'b1;
    r = full[9:0];
    f = '0;
    f[FLAG_NEG]  = r[9];
    f[FLAG_POS]  = !r[9] && (r != 10'd0);
    f[FLAG_ZERO] = (r == 10'd0);
    f[FLAG_ERR]  = err;
    return {f, r};
  endfunction

  always_comb {alu_flag, alu_res} = alu_fn(alu_oper, alu_arg0, alu_arg1);

  alu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_op      (cmd_op),
    .i_cmd_a       (cmd_a),
    .i_cmd_b       (cmd_b),
`ifdef ALU_ACCUM_EN
    .i_cmd_acc     (cmd_acc),
`endif
    .o_alu_arg0    (alu_arg0),
    .o_alu_arg1    (alu_arg1),
    .o_alu_oper    (alu_oper),
    .i_alu_result  (alu_res),
    .i_alu_flag    (alu_flag),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_res_data    (res_data),
    .o_res_flag    (res_flag),
    .o_sticky_flag (sticky),
    .i_sticky_clr  (sticky_clr),
    .o_done_cnt    (done_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    sticky_clr = 1'b0;
    sb_q.delete();
    model_last = '0;
    model_sticky = '0;
    model_done = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b,
                      input logic acc, input int max_wait, output bit ok);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_acc = acc;
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max_wait, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (res_valid) ok = 1'b1;
    end
  endtask

  task automatic drain(input int max_wait, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !res_valid) ok = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   acc_cnt;

    // Scoreboard: expectations enter on accepted pushes, leave on result handshakes.
    fork
      forever begin
        exp_t        e;
        logic [13:0] r;
        logic [11:0] a_eff;
        @(negedge clk);
        if (rst_n) begin
          if (res_valid && res_ready) begin
            check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
              e = sb_q.pop_front();
              check("sb_data", 32'(res_data), 32'(e.res));
              check("sb_flag", 32'(res_flag), 32'(e.flag));
              model_sticky = model_sticky | e.flag;
              model_done++;
            end
          end
          if (cmd_valid && cmd_ready) begin
            a_eff = (ACC_EN && cmd_acc) ? model_last : cmd_a;
            r = alu_fn(cmd_op, a_eff, cmd_b);
            e.flag = r[13:10];
            e.res  = r[9:0];
            sb_q.push_back(e);
            model_last = {{2{r[9]}}, r[9:0]};
          end
        end
      end
    join_none

    // Reset values
    do_reset();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_arg0", 32'(alu_arg0), 32'd0);
    check("rst_arg1", 32'(alu_arg1), 32'd0);
    check("rst_oper", 32'(alu_oper), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_flag", 32'(res_flag), 32'd0);
    check("rst_sticky", 32'(sticky), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);

    // Latency: add 100,200 pushed at E0, valid after E2
    res_ready = 1'b1;
    send(OP_ADD, 12'd100, 12'd200, 1'b0, 4, ok);
    check("lat_push", 32'(ok), 32'd1);
    @(negedge clk);
    check("lat_valid_e0", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_e1", 32'(res_valid), 32'd0);
    check("lat_arg0", 32'(alu_arg0), 32'd100);
    check("lat_arg1", 32'(alu_arg1), 32'd200);
    check("lat_oper", 32'(alu_oper), 32'(OP_ADD));
    @(negedge clk);
    check("lat_valid_e2", 32'(res_valid), 32'd1);
    check("lat_data", 32'(res_data), 32'd300);
    check("lat_flag", 32'(res_flag), 32'b0010);
    tick();

    // Divide by zero and sticky clear
    send(OP_DIV, 12'd5, 12'd0, 1'b0, 4, ok);
    wait_valid(8, ok);
    check("div0_valid", 32'(ok), 32'd1);
    check("div0_data", 32'(res_data), 32'd0);
    check("div0_flag", 32'(res_flag), 32'b1100);
    check("div0_sticky", 32'(sticky), 32'b1110);
    tick();
    tick();
    check("div0_sticky_held", 32'(sticky), 32'b1110);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_clr_alone", 32'(sticky), 32'd0);
    tick();

    // Clear coinciding with second capture
    do_reset();
    res_ready = 1'b1;
    send(OP_SUB, 12'hFFB, 12'd3, 1'b0, 4, ok);
    send(OP_XOR, 12'd0, 12'd0, 1'b0, 4, ok);
    tick();
    check("clr_sticky_first", 32'(sticky), 32'b0001);
    tick();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("clr_sticky_second", 32'(sticky), 32'b0100);
    drain(20, ok);
    check("clr_drain", 32'(ok), 32'd1);

    // Back-pressure: 1 held + DEPTH queued, then release keeps order
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      send(3'(i), 12'(i * 37 + 1), 12'(i + 2), 1'b0, 3, ok);
      if (ok) acc_cnt++;
    end
    check("full_accepted", 32'(acc_cnt), 32'd5);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_res_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    drain(40, ok);
    check("full_drain", 32'(ok), 32'd1);
    check("full_done_cnt", 32'(done_cnt), 32'd5);

    // Asynchronous reset while executing with three commands queued
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(OP_ADD, 12'(i + 10), 12'(i + 20), 1'b0, 3, ok);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #2 rst_n = 1'b0;
    sb_q.delete();
    model_last = '0;
    model_sticky = '0;
    model_done = 0;
    #1;
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_arg0", 32'(alu_arg0), 32'd0);
    check("mid_rst_arg1", 32'(alu_arg1), 32'd0);
    check("mid_rst_res_data", 32'(res_data), 32'd0);
    check("mid_rst_sticky", 32'(sticky), 32'd0);
    check("mid_rst_done_cnt", 32'(done_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_fifo_empty", 32'(res_valid), 32'd0);
    end
    tick();

`ifdef ALU_ACCUM_EN
    // Accumulate: second command takes the previous result as operand A
    do_reset();
    res_ready = 1'b1;
    send(OP_ADD, 12'd10, 12'd5, 1'b0, 4, ok);
    wait_valid(8, ok);
    check("acc_first", 32'(res_data), 32'd15);
    tick();
    send(OP_ADD, 12'h7A5, 12'd3, 1'b1, 4, ok);
    @(negedge clk);
    @(negedge clk);
    check("acc_arg0", 32'(alu_arg0), 32'd15);
    check("acc_arg1", 32'(alu_arg1), 32'd3);
    wait_valid(8, ok);
    check("acc_second", 32'(res_data), 32'd18);
    tick();
`endif

    // Randomized traffic with random consumer back-pressure
    do_reset();
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [11:0] ra, rb;
          logic        racc;
          ra = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 40)) - 12'd20 : 12'($urandom);
          rb = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(0, 30)) - 12'd15;
          racc = ACC_EN ? 1'($urandom_range(0, 1)) : 1'b0;
          repeat ($urandom_range(0, 2)) tick();
          send(3'($urandom), ra, rb, racc, 50, ok);
          if (!ok) check("rnd_send_accepted", 32'(ok), 32'd1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          res_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    res_ready = 1'b1;
    drain(60, ok);
    check("rnd_drain", 32'(ok), 32'd1);
    check("rnd_done_cnt", 32'(done_cnt), 32'(model_done[15:0]));
    check("rnd_sticky", 32'(sticky), 32'(model_sticky));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
